// File: rtl/score_pkg.sv
// score_pkg: shared types and defaults for the score BCD converter
// Holds the BCD digit type, the converter FSM state encoding and the
// default widths/saturation value used by the display path.
package score_pkg;
    typedef logic [3:0] bcd_digit_t;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t;
    localparam int SCORE_BIN_W  = 14;
    localparam int SCORE_DIGITS = 4;
    localparam int SCORE_SAT    = 9999;
endpackage

// File: rtl/score_bcd_converter_add3.sv
// bcd_add3: per-nibble shift-add-3 adjust
// Ports:
//   d  in   4  BCD nibble before adjust
//   q  out  4  d + 3 when d >= 5, else d (4-bit add, no carry out)
module bcd_add3
    import score_pkg::*;
(
    input  bcd_digit_t d,
    output bcd_digit_t q
);
    assign q = d >= 4'd5 ? d + 4'd3 : d;
endmodule

// File: rtl/score_bcd_converter.sv
// score_bcd_converter: sequential binary-to-BCD (shift-add-3) for the score display
// Ports:
//   clk        in   1      system clock
//   rst        in   1      asynchronous reset, active-high
//   bin_in     in   BIN_W  binary score, sampled on handshake
//   bin_valid  in   1      producer has a score to convert
//   bin_ready  out  1      converter idle and able to accept
//   dig0..3    out  4      BCD digits, dig0 ones .. dig3 thousands
//   dig_valid  out  1      one-cycle pulse when digits update
//   ovf        out  1      last accepted input was above SAT_VAL
module score_bcd_converter
    import score_pkg::*;
#(
    parameter int BIN_W   = SCORE_BIN_W,
    parameter int DIGITS  = SCORE_DIGITS,
    parameter int SAT_VAL = SCORE_SAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [BIN_W-1:0] bin_in,
    input  logic             bin_valid,
    output logic             bin_ready,
    output bcd_digit_t       dig0,
    output bcd_digit_t       dig1,
    output bcd_digit_t       dig2,
    output bcd_digit_t       dig3,
    output logic             dig_valid,
    output logic             ovf
);
    localparam int CW = $clog2(BIN_W);
    localparam logic [BIN_W-1:0] SAT = BIN_W'(SAT_VAL);

    conv_state_t           state, state_nxt;
    logic [CW-1:0]         bit_cnt;
    logic [BIN_W-1:0]      bin_sr;
    logic [4*DIGITS-1:0]   bcd_acc, adj;
    logic                  ovf_nxt;
    logic                  over;

    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_add3 u_add3 (.d(bcd_acc[4*i +: 4]), .q(adj[4*i +: 4]));
    end

    assign over      = bin_in > SAT;
    assign bin_ready = state == IDLE;

    always_comb begin
        state_nxt = state == IDLE  ? (bin_valid ? SHIFT : IDLE) :
                    state == SHIFT ? (bit_cnt == '0 ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            bin_sr    <= '0;
            bcd_acc   <= '0;
            ovf_nxt   <= 1'b0;
            dig0      <= '0;
            dig1      <= '0;
            dig2      <= '0;
            dig3      <= '0;
            dig_valid <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            state     <= state_nxt;
            dig_valid <= 1'b0;
            if (state == IDLE && bin_valid) begin
                bin_sr  <= over ? SAT : bin_in;
                bcd_acc <= '0;
                ovf_nxt <= over;
                bit_cnt <= CW'(BIN_W - 1);
            end else if (state == SHIFT) begin
                // adjust then shift; the binary MSB enters the BCD LSB
                {bcd_acc, bin_sr} <= {adj, bin_sr} << 1;
                bit_cnt           <= bit_cnt - 1'b1;
            end else if (state == DONE) begin
                dig0      <= bcd_acc[3:0];
                dig1      <= bcd_acc[7:4];
                dig2      <= bcd_acc[11:8];
                dig3      <= bcd_acc[15:12];
                ovf       <= ovf_nxt;
                dig_valid <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_score_bcd_converter.sv
// tb_score_bcd_converter: directed, table-driven check of score_bcd_converter
module tb_score_bcd_converter;
    import score_pkg::*;

    typedef struct {
        logic [13:0] val;
        logic [15:0] bcd;
        logic        ovf;
    } vec_t;

    logic        clk, rst, bin_valid, bin_ready, dig_valid, ovf;
    logic [13:0] bin_in;
    bcd_digit_t  dig0, dig1, dig2, dig3;
    int          n_cmp, n_bad;
    vec_t        vecs[9];

    score_bcd_converter dut (
        .clk(clk), .rst(rst), .bin_in(bin_in), .bin_valid(bin_valid),
        .bin_ready(bin_ready), .dig0(dig0), .dig1(dig1), .dig2(dig2),
        .dig3(dig3), .dig_valid(dig_valid), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] digits();
        return {dig3, dig2, dig1, dig0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic start(input logic [13:0] v);
        bin_in    = v;
        bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_valid = 1'b0;
    endtask

    // one conversion from IDLE: latency, ready-low span, result and pulse width
    task automatic conv(input string name, input logic [13:0] v,
                        input logic [15:0] bcd, input logic exp_ovf);
        int lat, low;
        chk({name, " ready_before"}, 32'(bin_ready), 1);
        start(v);
        lat = 0;
        low = 0;
        while (!dig_valid && lat < 40) begin
            if (!bin_ready) low++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, " latency"}, lat, 15);
        chk({name, " ready_low"}, low, 15);
        chk({name, " digits"}, 32'(digits()), 32'(bcd));
        chk({name, " ovf"}, 32'(ovf), 32'(exp_ovf));
        @(posedge clk); #1;
        chk({name, " pulse_1cyc"}, 32'(dig_valid), 0);
    endtask

    // watch n cycles: no dig_valid and digits stay 0000
    task automatic quiet(input string name, input int n);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (dig_valid || digits() != 16'h0000) ok = 1'b0;
            @(posedge clk); #1;
        end
        chk(name, 32'(ok), 1);
    endtask

    initial begin
        int t, gap;
        logic stable;
        n_cmp = 0;
        n_bad = 0;
        vecs[0] = '{14'd1234,  16'h1234, 1'b0};
        vecs[1] = '{14'd0,     16'h0000, 1'b0};
        vecs[2] = '{14'd9,     16'h0009, 1'b0};
        vecs[3] = '{14'd10,    16'h0010, 1'b0};
        vecs[4] = '{14'd9999,  16'h9999, 1'b0};
        vecs[5] = '{14'd10000, 16'h9999, 1'b1};
        vecs[6] = '{14'd16383, 16'h9999, 1'b1};
        vecs[7] = '{14'd42,    16'h0042, 1'b0};
        vecs[8] = '{14'd5678,  16'h5678, 1'b0};

        rst = 1'b1;
        bin_valid = 1'b0;
        bin_in = 14'd0;
        #12;
        chk("reset digits", 32'(digits()), 0);
        chk("reset dig_valid", 32'(dig_valid), 0);
        chk("reset ovf", 32'(ovf), 0);
        chk("reset ready", 32'(bin_ready), 1);
        bin_in = 14'd777;
        bin_valid = 1'b1;
        @(posedge clk); #1;
        chk("valid during rst ignored", 32'(bin_ready), 1);
        bin_valid = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 9; i++)
            conv($sformatf("vec%0d(%0d)", i, vecs[i].val), vecs[i].val, vecs[i].bcd, vecs[i].ovf);

        // async reset mid-conversion after an overflow result
        conv("pre_rst 16383", 14'd16383, 16'h9999, 1'b1);
        start(14'd1234);
        repeat (3) @(posedge clk);
        #4 rst = 1'b1;
        #1;
        chk("midrst digits", 32'(digits()), 0);
        chk("midrst dig_valid", 32'(dig_valid), 0);
        chk("midrst ovf", 32'(ovf), 0);
        chk("midrst ready", 32'(bin_ready), 1);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        quiet("midrst quiet", 20);

        // back-to-back with bin_valid held and a new value during conversion
        bin_in = 14'd100;
        bin_valid = 1'b1;
        @(posedge clk); #1;
        bin_in = 14'd200;
        t = 0;
        while (!dig_valid && t < 40) begin
            @(posedge clk); #1;
            t++;
        end
        chk("b2b first latency", t, 15);
        chk("b2b first digits", 32'(digits()), 32'h0100);
        @(posedge clk); #1;
        bin_valid = 1'b0;
        gap = 1;
        stable = 1'b1;
        while (!dig_valid && gap < 40) begin
            if (digits() != 16'h0100) stable = 1'b0;
            @(posedge clk); #1;
            gap++;
        end
        chk("b2b gap", gap, 16);
        chk("b2b digits held", 32'(stable), 1);
        chk("b2b second digits", 32'(digits()), 32'h0200);
        @(posedge clk); #1;

        // reset pulse at SHIFT cycle 7 of 5678, then a fresh 5678
        start(14'd5678);
        repeat (6) @(posedge clk);
        #2 rst = 1'b1;
        #3 rst = 1'b0;
        chk("shift7 rst digits", 32'(digits()), 0);
        @(posedge clk); #1;
        quiet("shift7 quiet", 20);
        conv("fresh 5678", 14'd5678, 16'h5678, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
